// File: rtl/gcd_method_responder.sv
// ---------------------------------------------------------------------------
// gcd_method_responder
//
// Callee side of a req / busy / return method-call handshake. A rising edge
// of gcd_req seen while idle latches gcd_a / gcd_b. The block then computes
// their greatest common divisor by iterative subtraction, one step per
// cycle. It holds gcd_busy high for the whole computation. When it finishes
// it drops gcd_busy, presents gcd_return and pulses gcd_done for one cycle.
//
// Parameters:
//   WIDTH       operand / result width (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   gcd_a       operand A, sampled when a call starts
//   gcd_b       operand B, sampled when a call starts
//   gcd_req     call request level; a call starts on its rising edge
//   gcd_busy    high from call start until the result is valid
//   gcd_return  result of the last completed call (0 after reset)
//   gcd_done    one-cycle pulse in the cycle gcd_busy falls
//   gcd_iters   (GCD_ITER_COUNT_EN only) number of CALC cycles used by the
//               last completed call, saturating at 32'hFFFFFFFF
//
// Optional feature macro: GCD_ITER_COUNT_EN
// ---------------------------------------------------------------------------
module gcd_method_responder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gcd_a,
    input  logic [WIDTH-1:0] gcd_b,
    input  logic             gcd_req,
    output logic             gcd_busy,
    output logic [WIDTH-1:0] gcd_return,
    output logic             gcd_done
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [31:0]      gcd_iters
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic             req_d;
    logic [WIDTH-1:0] ra, ra_nxt;
    logic [WIDTH-1:0] rb, rb_nxt;
    logic [WIDTH-1:0] result, result_nxt;
    logic             busy_nxt;
    logic [WIDTH-1:0] return_nxt;
    logic             done_nxt;
    logic             start;

`ifdef GCD_ITER_COUNT_EN
    logic [31:0] iter_cnt, iter_cnt_nxt;
    logic [31:0] iters_nxt;
`endif

    // A call starts only on a low-to-high transition of gcd_req seen while
    // idle. A request held high across a call therefore never retriggers.
    assign start = gcd_req && !req_d && (state == ST_IDLE);

    // Next-state and datapath logic.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        ra_nxt     = ra;
        rb_nxt     = rb;
        result_nxt = result;
        busy_nxt   = gcd_busy;
        return_nxt = gcd_return;
        done_nxt   = 1'b0;
`ifdef GCD_ITER_COUNT_EN
        iter_cnt_nxt = iter_cnt;
        iters_nxt    = gcd_iters;
`endif

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    ra_nxt    = gcd_a;
                    rb_nxt    = gcd_b;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_CALC;
`ifdef GCD_ITER_COUNT_EN
                    iter_cnt_nxt = '0;
`endif
                end
            end

            ST_CALC: begin
`ifdef GCD_ITER_COUNT_EN
                // Every CALC cycle counts, including the terminating one.
                iter_cnt_nxt = (iter_cnt == 32'hFFFF_FFFF) ? iter_cnt
                                                           : iter_cnt + 32'd1;
`endif
                // Terminal tests come first, so the subtractions below only
                // run with both operands non-zero and the larger one as the
                // minuend. They can never underflow.
                if (ra == '0) begin
                    result_nxt = rb;
                    state_nxt  = ST_DONE;
                end else if (rb == '0) begin
                    result_nxt = ra;
                    state_nxt  = ST_DONE;
                end else if (ra == rb) begin
                    result_nxt = ra;
                    state_nxt  = ST_DONE;
                end else if (ra > rb) begin
                    ra_nxt = ra - rb;
                end else begin
                    rb_nxt = rb - ra;
                end
            end

            ST_DONE: begin
                return_nxt = result;
                busy_nxt   = 1'b0;
                done_nxt   = 1'b1;
                state_nxt  = ST_IDLE;
`ifdef GCD_ITER_COUNT_EN
                iters_nxt = iter_cnt;
`endif
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything at once, so a
    // call in flight is abandoned without a gcd_done pulse.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            req_d      <= 1'b0;
            ra         <= '0;
            rb         <= '0;
            result     <= '0;
            gcd_busy   <= 1'b0;
            gcd_return <= '0;
            gcd_done   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            iter_cnt   <= '0;
            gcd_iters  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            req_d      <= gcd_req;
            ra         <= ra_nxt;
            rb         <= rb_nxt;
            result     <= result_nxt;
            gcd_busy   <= busy_nxt;
            gcd_return <= return_nxt;
            gcd_done   <= done_nxt;
`ifdef GCD_ITER_COUNT_EN
            iter_cnt   <= iter_cnt_nxt;
            gcd_iters  <= iters_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_gcd_method_responder.sv
// ---------------------------------------------------------------------------
// tb_gcd_method_responder
//
// Self-checking bench for gcd_method_responder (WIDTH = 32). A call-level
// reference model predicts busy / done / return (and gcd_iters when
// GCD_ITER_COUNT_EN is defined). The model uses Euclid's modulo algorithm
// for the result and a plain step count for the latency. A compare process
// checks the DUT against the model on every falling edge. Directed calls
// also check hand-computed literal results and busy durations.
// ---------------------------------------------------------------------------
module tb_gcd_method_responder;

    localparam int W       = 32;
    localparam int T_BOUND = 2000;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] gcd_a = '0;
    logic [W-1:0] gcd_b = '0;
    logic         gcd_req = 1'b0;
    logic         gcd_busy;
    logic [W-1:0] gcd_return;
    logic         gcd_done;
`ifdef GCD_ITER_COUNT_EN
    logic [31:0]  gcd_iters;
`endif

    int errors = 0;
    int checks = 0;

    gcd_method_responder #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_req    (gcd_req),
        .gcd_busy   (gcd_busy),
        .gcd_return (gcd_return),
        .gcd_done   (gcd_done)
`ifdef GCD_ITER_COUNT_EN
        ,
        .gcd_iters  (gcd_iters)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Number of compute cycles: one per subtraction plus one for the
    // terminating test. The count saturates at 32 bits.
    function automatic longint ref_steps(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        longint k = 1;
        while (!(a == 0 || b == 0 || a == b)) begin
            if (a > b) a = a - b;
            else       b = b - a;
            k++;
        end
        if (k > 64'hFFFF_FFFF) k = 64'hFFFF_FFFF;
        return k;
    endfunction

    // A call occupies (k + 1) cycles of busy after its sampling edge. Its
    // result appears together with a single done pulse.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_ret  = '0;
    logic [31:0]  m_iters = '0;
    logic         m_req_prev = 1'b0;
    longint       m_remaining = 0;
    logic [W-1:0] pend_ret = '0;
    longint       pend_k = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy      <= 1'b0;
            m_done      <= 1'b0;
            m_ret       <= '0;
            m_iters     <= '0;
            m_req_prev  <= 1'b0;
            m_remaining <= 0;
        end else begin
            m_req_prev <= gcd_req;
            m_done     <= 1'b0;
            if (m_remaining != 0) begin
                m_remaining <= m_remaining - 1;
                if (m_remaining == 1) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_ret   <= pend_ret;
                    m_iters <= 32'(pend_k);
                end
            end else if (gcd_req && !m_req_prev) begin
                pend_ret    <= ref_gcd(gcd_a, gcd_b);
                pend_k      <= ref_steps(gcd_a, gcd_b);
                m_remaining <= ref_steps(gcd_a, gcd_b) + 1;
                m_busy      <= 1'b1;
            end
        end
    end

    // Compare process: check outputs against the model at every falling
    // edge, away from the active clock edge.
    always @(negedge clk) begin
        check("cmp_busy", gcd_busy, m_busy);
        check("cmp_done", gcd_done, m_done);
        check("cmp_return", gcd_return, m_ret);
`ifdef GCD_ITER_COUNT_EN
        check("cmp_iters", gcd_iters, m_iters);
`endif
    end

    // ---------------- directed stimulus ----------------
    // Make one call and check its result and busy duration. The request is
    // left high when keep_req is set.
    task automatic do_call(input string name, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_ret,
                           input int exp_k, input bit keep_req);
        int n;
        gcd_a   = a;
        gcd_b   = b;
        gcd_req = 1'b1;
        @(negedge clk);
        check({name, "_busy_rise"}, gcd_busy, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gcd_done && n < T_BOUND);
        check({name, "_done_seen"}, gcd_done, 1'b1);
        check({name, "_busy_cycles"}, 64'(n), 64'(exp_k + 1));
        check({name, "_return"}, gcd_return, exp_ret);
`ifdef GCD_ITER_COUNT_EN
        check({name, "_iters"}, gcd_iters, 32'(exp_k));
`endif
        if (!keep_req) gcd_req = 1'b0;
    endtask

    initial begin
        int n;

        // Reset is held low from time zero through cycle 8.
        repeat (4) @(negedge clk);
        check("reset_busy", gcd_busy, 1'b0);
        check("reset_return", gcd_return, '0);
        check("reset_done", gcd_done, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (91) @(negedge clk);

        // gcd(12,8): request stays high afterwards and must not retrigger.
        do_call("g12_8", 32'd12, 32'd8, 32'd4, 3, 1'b1);
        repeat (6) @(negedge clk);
        check("held_req_no_retrigger", gcd_busy, 1'b0);
        gcd_req = 1'b0;
        @(negedge clk);

        // Special values.
        do_call("g0_0", 32'd0, 32'd0, 32'd0, 1, 1'b0);
        @(negedge clk);
        do_call("g0_35", 32'd0, 32'd35, 32'd35, 1, 1'b0);
        @(negedge clk);
        do_call("g35_0", 32'd35, 32'd0, 32'd35, 1, 1'b0);
        @(negedge clk);

        // Long data-dependent latency: 254 subtractions plus the final test.
        do_call("g255_1", 32'd255, 32'd1, 32'd1, 255, 1'b0);
        @(negedge clk);

        // Request re-pulsed mid-CALC with different operands: ignored.
        gcd_a   = 32'd100;
        gcd_b   = 32'd75;
        gcd_req = 1'b1;
        @(negedge clk);
        gcd_req = 1'b0;
        gcd_a   = 32'd7;
        gcd_b   = 32'd3;
        @(negedge clk);
        gcd_req = 1'b1;
        @(negedge clk);
        check("repulse_still_busy", gcd_busy, 1'b1);
        gcd_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gcd_done && n < T_BOUND);
        check("g100_75_done_seen", gcd_done, 1'b1);
        check("g100_75_return", gcd_return, 32'd25);
        @(negedge clk);
        do_call("g21_14", 32'd21, 32'd14, 32'd7, 3, 1'b0);
        @(negedge clk);

        // Reset during the computation of gcd(1000,3).
        gcd_a   = 32'd1000;
        gcd_b   = 32'd3;
        gcd_req = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_calc_busy", gcd_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_busy", gcd_busy, 1'b0);
        check("abort_return", gcd_return, '0);
        check("abort_done", gcd_done, 1'b0);
        gcd_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_call("g9_6", 32'd9, 32'd6, 32'd3, 3, 1'b0);
        @(negedge clk);

        // Operands changed every cycle during CALC of gcd(48,18).
        gcd_a   = 32'd48;
        gcd_b   = 32'd18;
        gcd_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            gcd_a = 32'(n * 7 + 3);
            gcd_b = 32'(n * 13 + 1);
        end while (!gcd_done && n < T_BOUND);
        check("g48_18_done_seen", gcd_done, 1'b1);
        check("g48_18_cycles", 64'(n), 64'd7);
        check("g48_18_return", gcd_return, 32'd6);
        gcd_req = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gcd_method_responder.md
Name: gcd_method_responder

Overview:
- Responder (callee) side of the method-call handshake: req / busy / return.
- A caller raises `gcd_req`. The block latches two operands and computes their greatest common divisor by iterative subtraction.
- It holds `gcd_busy` high while computing, then drops `gcd_busy` with `gcd_return` valid.
- Serves as the reusable target for simulation benches and as the hardware model of a synthesized method body.

Parameters:
- WIDTH, 32, operand and result bit width (>=2).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- gcd_a  input  WIDTH  operand A, sampled on call start.
- gcd_b  input  WIDTH  operand B, sampled on call start.
- gcd_req  input  1  call request (level); a call starts on its rising edge.
- gcd_busy  output  1  high from call start until the result is valid.
- gcd_return  output  WIDTH  GCD result; valid whenever `gcd_busy`=0 after at least one completed call.
- gcd_done  output  1  one-cycle pulse in the cycle `gcd_busy` falls.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; `gcd_busy`=0, `gcd_return`=0, `gcd_done`=0.
  - Registered copy `req_d`=0.
  - Working registers ra, rb = 0.
- `req_d` <= `gcd_req` every cycle. Start condition: `gcd_req`=1 && `req_d`=0 && state==IDLE.
- Holding `gcd_req` high does not retrigger. Each new call needs a low-to-high transition seen while IDLE.
- IDLE:
  - On start: ra<=`gcd_a`, rb<=`gcd_b`, `gcd_busy`<=1, state<=CALC.
  - `gcd_busy` is therefore high in the cycle after the sampling edge.
- CALC, one step per cycle, in priority order:
  - ra==0: result<=rb, goto DONE.
  - rb==0: result<=ra, goto DONE.
  - ra==rb: result<=ra, goto DONE.
  - ra>rb: ra<=ra-rb.
  - else: rb<=rb-ra.
  - Arithmetic is unsigned WIDTH-bit. Subtraction never underflows because of the compare.
- DONE:
  - `gcd_return`<=result, `gcd_busy`<=0, `gcd_done`<=1 for exactly one cycle.
  - state<=IDLE.
  - `gcd_return` then holds its value until the next DONE.
- Latency: start-sampling edge to `gcd_busy` fall = 1 (load) + k (CALC cycles, k>=1) + 1 (DONE) edges.
  - gcd(12,8): CALC steps 12,8 -> 4,8 -> 4,4 -> equal, so k=3; busy high for 4 cycles.
- Special values:
  - gcd(0,x)=x.
  - gcd(x,0)=x.
  - gcd(0,0)=0 (k=1).
- Worst case k = 2^WIDTH-1 (gcd(max,1)). The caller must tolerate data-dependent latency; no timeout inside the block.
- Rising edge of `gcd_req` while `gcd_busy`=1: ignored, no restart, operands unchanged.
  - If `gcd_req` is still high when the block returns to IDLE, no new call starts; the caller must lower and re-raise it.
- Operand changes during CALC have no effect; operands are latched.
- Reset mid-operation: immediately returns to IDLE with all outputs cleared. `gcd_done` is not pulsed.
- `gcd_done` and `gcd_busy` are never high in the same cycle.

Optional Feature:
- Macro GCD_ITER_COUNT_EN.
- When defined:
  - Adds output port `gcd_iters` (output, 32 bits) = number of CALC cycles k of the last completed call.
  - The counter clears on call start and saturates at 32'hFFFFFFFF.
  - It is updated together with `gcd_return` in DONE; reset value 0.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset held low cycles 3-8, then a=12, b=8, `gcd_req` raised at cycle 100 and held -> busy rises next cycle, busy low within 4 cycles; `gcd_return`=4, one `gcd_done` pulse, busy remains 0 despite req still high.
- a=0, b=0 -> `gcd_return`=0, k=1; a=0, b=35 -> 35; a=35, b=0 -> 35.
- a=32'hFFFFFFFF, b=32'hFFFFFFFE, WIDTH=32 -> `gcd_return`=1; bench timeout above 2^32 not required; use WIDTH=8, a=255, b=1 -> 1 after k=255 (`gcd_iters`=255 with GCD_ITER_COUNT_EN).
- Pulse `gcd_req` again mid-CALC of gcd(100,75) with different operands -> ignored, `gcd_return`=25; lower/raise afterwards with a=21, b=14 -> 7.
- Assert reset low during CALC of gcd(1000,3) -> `gcd_busy`=0, `gcd_return`=0 immediately, no `gcd_done`; the next call gcd(9,6) -> 3.
- Change `gcd_a`/`gcd_b` every cycle during CALC of gcd(48,18) -> result 6.
